// File: rtl/puf_soc_pkg.sv
// Shared types and defaults for the RO-PUF sequencer: FSM state encoding,
// select-width and phase-counter-width helpers, default timing constants.
package puf_soc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_MEASURE,
        ST_DRAIN,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam int DEF_MUX_LENGTH = 16;
    localparam int DEF_N_BITS     = 8;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_SETTLE_CYC = 4;
    localparam int DEF_WINDOW_CYC = 1024;
    localparam int DEF_DRAIN_CYC  = 2;

    function automatic int sel_width(input int n_ro);
        return (n_ro > 1) ? $clog2(n_ro) : 1;
    endfunction

    // Wide enough to hold the longest phase length plus one.
    function automatic int phase_width(input int s, input int w, input int d);
        int m;
        m = s;
        if (w > m) m = w;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/puf_soc_ro_cmp.sv
// Registered unsigned comparator for the two RO edge counts; the controller
// consumes {gt, eq} in CAPTURE, one cycle after the counts were sampled.
module puf_soc_ro_cmp #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt_0,
    input  logic [CNT_W-1:0] cnt_1,
    output logic             gt,
    output logic             eq
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt <= 1'b0;
            eq <= 1'b0;
        end else begin
            gt <= (cnt_0 > cnt_1);
            eq <= (cnt_0 == cnt_1);
        end
    end

endmodule

// File: rtl/puf_soc_ro_ctrl.sv
// RO-PUF challenge sequencer: walks N_BITS RO pairs, gates the ROs, times the
// settle/count/drain phases and packs one response bit per pair.
module puf_soc_ro_ctrl
    import puf_soc_pkg::*;
#(
    parameter int MUX_LENGTH = DEF_MUX_LENGTH,
    parameter int N_BITS     = DEF_N_BITS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int WINDOW_CYC = DEF_WINDOW_CYC,
    parameter int DRAIN_CYC  = DEF_DRAIN_CYC,
    localparam int SEL_W     = sel_width(MUX_LENGTH)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_start,
    input  logic                      i_abort,
    input  logic [N_BITS*2*SEL_W-1:0] i_challenge,
    output logic [SEL_W-1:0]          o_sel_mux_0,
    output logic [SEL_W-1:0]          o_sel_mux_1,
    output logic                      o_dcod_en,
    output logic                      o_ro_run,
    output logic                      o_cnt_clr,
    output logic                      o_cnt_en,
    input  logic [CNT_W-1:0]          i_cnt_0,
    input  logic [CNT_W-1:0]          i_cnt_1,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [N_BITS-1:0]         o_response,
    output logic [N_BITS-1:0]         o_tie,
    output logic [N_BITS-1:0]         o_invalid
);

    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam int PH_W  = phase_width(SETTLE_CYC, WINDOW_CYC, DRAIN_CYC);
    localparam int CH_W  = N_BITS * 2 * SEL_W;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_BITS - 1);
    localparam logic [PH_W-1:0]  SETTLE_LD = PH_W'(SETTLE_CYC - 1);
    localparam logic [PH_W-1:0]  WINDOW_LD = PH_W'(WINDOW_CYC - 1);
    localparam logic [PH_W-1:0]  DRAIN_LD  = PH_W'(DRAIN_CYC - 1);

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [CH_W-1:0]    challenge_reg, challenge_next;
    logic [PH_W-1:0]    phase_reg, phase_next;
    logic [SEL_W-1:0]   sel0_reg, sel0_next;
    logic [SEL_W-1:0]   sel1_reg, sel1_next;
    logic               pair_invalid_reg, pair_invalid_next;
    logic [N_BITS-1:0]  response_reg, response_next;
    logic [N_BITS-1:0]  tie_reg, tie_next;
    logic [N_BITS-1:0]  invalid_reg, invalid_next;
    logic               dcod_en_reg, ro_run_reg, cnt_clr_reg, cnt_en_reg;
    logic               busy_reg, done_reg;
    logic               cmp_gt, cmp_eq;
    logic [SEL_W-1:0]   pair_sel0 [N_BITS];
    logic [SEL_W-1:0]   pair_sel1 [N_BITS];

    // Slice the (possibly just-latched) challenge into per-pair selects.
    for (genvar gi = 0; gi < N_BITS; gi++) begin : g_pair
        assign pair_sel0[gi] = challenge_next[(2*gi)*SEL_W +: SEL_W];
        assign pair_sel1[gi] = challenge_next[(2*gi+1)*SEL_W +: SEL_W];
    end

    assign sel0_next = (state_next == ST_LOAD) ? pair_sel0[idx_next] : sel0_reg;
    assign sel1_next = (state_next == ST_LOAD) ? pair_sel1[idx_next] : sel1_reg;

    puf_soc_ro_cmp #(.CNT_W(CNT_W)) u_cmp (
        .clk   (clk),
        .rst_n (rst_n),
        .cnt_0 (i_cnt_0),
        .cnt_1 (i_cnt_1),
        .gt    (cmp_gt),
        .eq    (cmp_eq)
    );

    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        challenge_next    = challenge_reg;
        phase_next        = phase_reg;
        pair_invalid_next = pair_invalid_reg;
        response_next     = response_reg;
        tie_next          = tie_reg;
        invalid_next      = invalid_reg;

        if (i_abort && (state_reg != ST_IDLE)) begin
            state_next    = ST_IDLE;
            response_next = '0;
            tie_next      = '0;
            invalid_next  = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_start && !i_abort) begin
                        challenge_next = i_challenge;
                        idx_next       = '0;
                        response_next  = '0;
                        tie_next       = '0;
                        invalid_next   = '0;
                        state_next     = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // A pair that selects the same RO twice is never measured.
                    if (sel0_reg == sel1_reg) begin
                        pair_invalid_next = 1'b1;
                        state_next        = ST_CAPTURE;
                    end else begin
                        pair_invalid_next = 1'b0;
                        phase_next        = SETTLE_LD;
                        state_next        = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (phase_reg == '0) begin
                        phase_next = WINDOW_LD;
                        state_next = ST_MEASURE;
                    end else begin
                        phase_next = phase_reg - 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (phase_reg == '0) begin
                        phase_next = DRAIN_LD;
                        state_next = ST_DRAIN;
                    end else begin
                        phase_next = phase_reg - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (phase_reg == '0) begin
                        state_next = ST_CAPTURE;
                    end else begin
                        phase_next = phase_reg - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    response_next[idx_reg] = !pair_invalid_reg && cmp_gt;
                    tie_next[idx_reg]      = !pair_invalid_reg && cmp_eq;
                    invalid_next[idx_reg]  = pair_invalid_reg;
                    if (idx_reg == LAST_IDX) begin
                        state_next = ST_DONE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = ST_LOAD;
                    end
                end
                ST_DONE: state_next = ST_IDLE;
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Strobes are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ST_IDLE;
            idx_reg          <= '0;
            challenge_reg    <= '0;
            phase_reg        <= '0;
            sel0_reg         <= '0;
            sel1_reg         <= '0;
            pair_invalid_reg <= 1'b0;
            response_reg     <= '0;
            tie_reg          <= '0;
            invalid_reg      <= '0;
            dcod_en_reg      <= 1'b0;
            ro_run_reg       <= 1'b0;
            cnt_clr_reg      <= 1'b0;
            cnt_en_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            idx_reg          <= idx_next;
            challenge_reg    <= challenge_next;
            phase_reg        <= phase_next;
            sel0_reg         <= sel0_next;
            sel1_reg         <= sel1_next;
            pair_invalid_reg <= pair_invalid_next;
            response_reg     <= response_next;
            tie_reg          <= tie_next;
            invalid_reg      <= invalid_next;
            dcod_en_reg      <= (state_next == ST_LOAD);
            cnt_clr_reg      <= (state_next == ST_LOAD);
            ro_run_reg       <= (state_next == ST_SETTLE) || (state_next == ST_MEASURE);
            cnt_en_reg       <= (state_next == ST_MEASURE);
            busy_reg         <= (state_next != ST_IDLE);
            done_reg         <= (state_next == ST_DONE);
        end
    end

    assign o_sel_mux_0 = sel0_reg;
    assign o_sel_mux_1 = sel1_reg;
    assign o_dcod_en   = dcod_en_reg;
    assign o_ro_run    = ro_run_reg;
    assign o_cnt_clr   = cnt_clr_reg;
    assign o_cnt_en    = cnt_en_reg;
    assign o_busy      = busy_reg;
    assign o_done      = done_reg;
    assign o_response  = response_reg;
    assign o_tie       = tie_reg;
    assign o_invalid   = invalid_reg;

endmodule

// File: tb/tb_puf_soc_ro_ctrl.sv
// Self-checking bench for puf_soc_ro_ctrl: directed scenarios plus randomized
// challenges, checked against a per-RO count table and a pair-level model.
module tb_puf_soc_ro_ctrl;

    localparam int NB = 4;
    localparam int SW = 4;
    localparam int CW = 16;
    localparam int ST = 2;
    localparam int WN = 16;
    localparam int DR = 2;
    localparam int PAIR_CYC = 1 + ST + WN + DR + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [31:0]   i_challenge = '0;
    logic [SW-1:0] o_sel_mux_0, o_sel_mux_1;
    logic          o_dcod_en, o_ro_run, o_cnt_clr, o_cnt_en;
    logic [CW-1:0] i_cnt_0, i_cnt_1;
    logic          o_busy, o_done;
    logic [NB-1:0] o_response, o_tie, o_invalid;

    // Final edge count each RO would reach over the window.
    logic [CW-1:0] ro_cnt [16];
    assign i_cnt_0 = ro_cnt[o_sel_mux_0];
    assign i_cnt_1 = ro_cnt[o_sel_mux_1];

    puf_soc_ro_ctrl #(
        .MUX_LENGTH(16), .N_BITS(NB), .CNT_W(CW),
        .SETTLE_CYC(ST), .WINDOW_CYC(WN), .DRAIN_CYC(DR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_abort(i_abort),
        .i_challenge(i_challenge), .o_sel_mux_0(o_sel_mux_0), .o_sel_mux_1(o_sel_mux_1),
        .o_dcod_en(o_dcod_en), .o_ro_run(o_ro_run), .o_cnt_clr(o_cnt_clr), .o_cnt_en(o_cnt_en),
        .i_cnt_0(i_cnt_0), .i_cnt_1(i_cnt_1), .o_busy(o_busy), .o_done(o_done),
        .o_response(o_response), .o_tie(o_tie), .o_invalid(o_invalid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int dcod_total = 0, en_total = 0, run_total = 0, done_total = 0;
    logic [7:0] sel_hist [64];

    always @(negedge clk) begin
        if (o_dcod_en) begin
            sel_hist[dcod_total % 64] <= {o_sel_mux_1, o_sel_mux_0};
            dcod_total <= dcod_total + 1;
        end
        if (o_cnt_en) en_total <= en_total + 1;
        if (o_ro_run) run_total <= run_total + 1;
        if (o_done) done_total <= done_total + 1;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    function automatic logic [31:0] all_outs();
        return {6'd0, o_sel_mux_0, o_sel_mux_1, o_dcod_en, o_ro_run, o_cnt_clr, o_cnt_en,
                o_busy, o_done, o_response, o_tie, o_invalid};
    endfunction

    function automatic logic [31:0] mk_ch(input int a0, b0, a1, b1, a2, b2, a3, b3);
        return {4'(b3), 4'(a3), 4'(b2), 4'(a2), 4'(b1), 4'(a1), 4'(b0), 4'(a0)};
    endfunction

    task automatic set_tbl(input int even_v, input int odd_v);
        for (int r = 0; r < 16; r++) ro_cnt[r] = CW'((r % 2 == 0) ? even_v : odd_v);
    endtask

    // Pair-level reference: compare table counts, flag same-RO pairs.
    task automatic model(input logic [31:0] ch, output logic [NB-1:0] r, output logic [NB-1:0] t,
                         output logic [NB-1:0] v, output int lat, output int nvalid);
        logic [31:0] chv;
        int s0, s1;
        chv = ch; r = '0; t = '0; v = '0; lat = 1; nvalid = 0;
        for (int k = 0; k < NB; k++) begin
            s0 = int'(chv[8*k +: 4]);
            s1 = int'(chv[8*k+4 +: 4]);
            if (s0 == s1) begin
                v[k] = 1'b1; lat += 2;
            end else begin
                r[k] = ro_cnt[s0] > ro_cnt[s1];
                t[k] = ro_cnt[s0] == ro_cnt[s1];
                lat += PAIR_CYC; nvalid++;
            end
        end
    endtask

    task automatic run_and_check(input string name, input logic [31:0] ch,
                                 input bit mid_start, input logic [31:0] ch2);
        logic [NB-1:0] er, et, ev;
        logic [31:0] chv;
        int elat, nval, cyc, d0, e0, r0, n0;
        model(ch, er, et, ev, elat, nval);
        chv = ch;
        d0 = dcod_total; e0 = en_total; r0 = run_total; n0 = done_total;
        @(negedge clk);
        i_challenge = ch; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (c == 1) check({name, " load_strobes"}, {o_busy, o_dcod_en, o_cnt_clr, o_ro_run}, 4'b1110);
            if (mid_start && c == 6) begin
                check({name, " in_measure"}, {o_cnt_en, o_ro_run}, 2'b11);
                i_challenge = ch2; i_start = 1'b1;
                @(posedge clk); #1 i_start = 1'b0;
            end
            if (o_done) begin cyc = c; break; end
        end
        check({name, " latency"}, cyc, elat);
        check({name, " response"}, o_response, er);
        check({name, " tie"}, o_tie, et);
        check({name, " invalid"}, o_invalid, ev);
        @(negedge clk); #1;
        check({name, " done_one_cycle"}, {o_done, o_busy}, 2'b00);
        check({name, " hold_flags"}, {o_response, o_tie, o_invalid}, {er, et, ev});
        check({name, " dcod_pulses"}, dcod_total - d0, NB);
        check({name, " cnt_en_cycles"}, en_total - e0, nval * WN);
        check({name, " ro_run_cycles"}, run_total - r0, nval * (ST + WN));
        check({name, " done_pulses"}, done_total - n0, 1);
        for (int k = 0; k < NB; k++)
            check({name, " sel_pair"}, sel_hist[(d0 + k) % 64], chv[8*k +: 8]);
    endtask

    initial begin
        logic [31:0] ch_a, ch_b, ch_r;
        int d0, n0, found;

        ch_a = mk_ch(0, 1, 2, 3, 4, 5, 6, 7);
        ch_b = mk_ch(0, 1, 2, 3, 5, 5, 6, 7);
        set_tbl(100, 90);

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("reset_outputs", all_outs(), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", all_outs(), 32'd0);

        // All pairs valid, cnt0 > cnt1
        run_and_check("all_gt", ch_a, 1'b0, 32'd0);

        // Pair 2 invalid, others cnt0 < cnt1
        set_tbl(10, 20);
        run_and_check("invalid_pair2", ch_b, 1'b0, 32'd0);

        // Pair 1 tied
        set_tbl(100, 90);
        ro_cnt[2] = 16'd50; ro_cnt[3] = 16'd50;
        run_and_check("tie_pair1", ch_a, 1'b0, 32'd0);

        // Abort during MEASURE of pair 1
        d0 = dcod_total; n0 = done_total; found = 0;
        @(negedge clk);
        i_challenge = ch_a; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if ((dcod_total - d0) >= 2 && o_cnt_en) begin found = 1; break; end
        end
        check("abort_reached_measure", found, 1);
        check("abort_partial_resp", o_response, 4'b0001);
        i_abort = 1'b1;
        @(posedge clk); #1 i_abort = 1'b0;
        check("abort_outputs", {o_busy, o_cnt_en, o_ro_run, o_dcod_en, o_done}, 5'b0);
        check("abort_flags", {o_response, o_tie, o_invalid}, 12'd0);
        repeat (30) @(negedge clk);
        check("abort_no_done", done_total - n0, 0);
        check("abort_stays_idle", o_busy, 1'b0);

        // Start and abort together in IDLE: start ignored
        @(negedge clk);
        i_challenge = ch_a; i_start = 1'b1; i_abort = 1'b1;
        @(posedge clk); #1 i_start = 1'b0; i_abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", {o_busy, o_dcod_en}, 2'b00);

        // Start while busy is ignored
        set_tbl(30, 70);
        ro_cnt[0] = 16'd200;
        run_and_check("busy_start_ignored", ch_a, 1'b1, mk_ch(1, 0, 3, 3, 9, 8, 15, 14));

        // Asynchronous reset during MEASURE
        d0 = dcod_total; found = 0;
        @(negedge clk);
        i_challenge = ch_a; i_start = 1'b1;
        @(posedge clk); #1 i_start = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (o_cnt_en) begin found = 1; break; end
        end
        check("rst_reached_measure", found, 1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", all_outs(), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        set_tbl(100, 90);
        run_and_check("after_reset", ch_a, 1'b0, 32'd0);

        // Randomized challenges and count tables
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < 16; r++) ro_cnt[r] = CW'($urandom_range(0, 5) * 1000 + $urandom_range(0, 2));
            ch_r = $urandom;
            for (int k = 0; k < NB; k++)
                if ($urandom_range(0, 3) == 0) ch_r[8*k+4 +: 4] = ch_r[8*k +: 4];
            run_and_check($sformatf("random%0d", it), ch_r, 1'b0, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
